// File: rtl/tr_pkg.sv
// Shared types and helpers for the tr_track_stepper tracking regulator.
// Holds the FSM state and zone enums, the timer width and the absolute-difference helper.
package tr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIR      = 2'd1,
        PULSE_HI = 2'd2,
        PULSE_LO = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } zone_t;

    // Wide enough for any step period or setup delay used by the regulator
    localparam int TR_CNT_W = 16;

    // |a - b| for unsigned operands; callers zero-extend to 32 bits and truncate the result
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

endpackage

// File: rtl/tr_step_gen.sv
// Loadable down-counter used by the stepper FSM for pulse-high, pulse-low and direction-setup timing.
// Loading N makes done assert during the N-th cycle after the load edge.
module tr_step_gen
    import tr_pkg::*;
#(
    parameter int CNT_W = TR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    // Count down from the loaded value and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/tr_track_stepper.sv
// Tracking regulator: compares ADC samples with a setpoint and drives a step/dir motor driver toward it,
// with a deadband, slow/fast step zones, direction-setup delay and a signed position counter.
// Optional build macro TR_AVG_EN: average 2^AVG_LOG2 samples before each decision.
module tr_track_stepper
    import tr_pkg::*;
#(
    parameter int W         = 12,
    parameter int POS_W     = 16,
    parameter int PULSE_W   = 4,
    parameter int SLOW_DIV  = 40,
    parameter int FAST_DIV  = 10,
    parameter int DIR_SETUP = 3
`ifdef TR_AVG_EN
    ,parameter int AVG_LOG2 = 2
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    data_valid,
    input  logic [W-1:0]            x,
    input  logic [W-1:0]            x0,
    input  logic [W-1:0]            dx1,
    input  logic [W-1:0]            dx2,
    output logic                    drv_SM,
    output logic                    drv_step,
    output logic                    drv_dir,
    output logic                    in_window,
    output logic                    busy,
    output logic signed [POS_W-1:0] pos
);

    localparam logic [TR_CNT_W-1:0] LD_HI      = TR_CNT_W'(PULSE_W);
    localparam logic [TR_CNT_W-1:0] LD_SLOW_LO = TR_CNT_W'(SLOW_DIV - PULSE_W);
    localparam logic [TR_CNT_W-1:0] LD_FAST_LO = TR_CNT_W'(FAST_DIV - PULSE_W);
    localparam logic [TR_CNT_W-1:0] LD_DIR     = TR_CNT_W'(DIR_SETUP);

    state_t                  r_state;
    zone_t                   r_zone;
    logic                    r_sm;
    logic                    r_step;
    logic                    r_dir;
    logic                    r_in_window;
    logic                    r_busy;
    logic signed [POS_W-1:0] r_pos;

    logic                    w_valid;
    logic [W-1:0]            w_x;
    logic [W-1:0]            w_abs;
    logic                    w_new_dir;
    logic                    w_decide;
    zone_t                   w_zone;
    logic signed [POS_W-1:0] w_pos_step;
    logic                    w_load;
    logic [TR_CNT_W-1:0]     w_load_val;
    logic                    w_done;

`ifdef TR_AVG_EN
    localparam int SUM_W = W + AVG_LOG2;

    logic [SUM_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic                r_avg_valid;
    logic [W-1:0]        r_avg_x;
    logic [SUM_W-1:0]    w_sum;

    assign w_sum = r_acc + SUM_W'(x);

    // Accumulate enabled samples; every 2^AVG_LOG2 samples emit the truncated mean as a one-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= {SUM_W{1'b0}};
            r_cnt       <= {AVG_LOG2{1'b0}};
            r_avg_valid <= 1'b0;
            r_avg_x     <= {W{1'b0}};
        end else if (!enable) begin
            r_acc       <= {SUM_W{1'b0}};
            r_cnt       <= {AVG_LOG2{1'b0}};
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (data_valid) begin
                if (r_cnt == {AVG_LOG2{1'b1}}) begin
                    r_avg_x     <= w_sum[SUM_W-1:AVG_LOG2];
                    r_avg_valid <= 1'b1;
                    r_acc       <= {SUM_W{1'b0}};
                    r_cnt       <= {AVG_LOG2{1'b0}};
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + AVG_LOG2'(1);
                end
            end
        end
    end

    assign w_valid = r_avg_valid;
    assign w_x     = r_avg_x;
`else
    assign w_valid = data_valid;
    assign w_x     = x;
`endif

    assign w_abs      = W'(abs_diff(32'(w_x), 32'(x0)));
    assign w_new_dir  = (w_x < x0);
    assign w_decide   = (r_state == IDLE) && w_valid && enable;
    // The direction is already final when a pulse starts, so the step sign comes from r_dir
    assign w_pos_step = r_dir ? POS_W'(1) : {POS_W{1'b1}};

    // Classify the current error against the deadband and the fast threshold
    always_comb begin
        w_zone = HOLD;
        if (w_abs <= dx1) begin
            w_zone = HOLD;
        end else if (w_abs <= dx2) begin
            w_zone = SLOW;
        end else begin
            w_zone = FAST;
        end
    end

    // Timer loads coincide with the FSM transitions that start a timed state
    always_comb begin
        w_load     = 1'b0;
        w_load_val = LD_HI;
        case (r_state)
            IDLE: begin
                if (w_decide && (w_zone != HOLD)) begin
                    w_load     = 1'b1;
                    w_load_val = (w_new_dir != r_dir) ? LD_DIR : LD_HI;
                end else begin
                    w_load = 1'b0;
                end
            end
            DIR: begin
                if (enable && w_done) begin
                    w_load     = 1'b1;
                    w_load_val = LD_HI;
                end else begin
                    w_load = 1'b0;
                end
            end
            PULSE_HI: begin
                if (enable && w_done) begin
                    w_load     = 1'b1;
                    w_load_val = (r_zone == FAST) ? LD_FAST_LO : LD_SLOW_LO;
                end else begin
                    w_load = 1'b0;
                end
            end
            PULSE_LO: w_load = 1'b0;
            default:  w_load = 1'b0;
        endcase
    end

    tr_step_gen #(
        .CNT_W(TR_CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_done)
    );

    // Stepper FSM: decides in IDLE, inserts direction setup, times the step pulse and owns every output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_zone      <= HOLD;
            r_sm        <= 1'b0;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
            r_in_window <= 1'b0;
            r_busy      <= 1'b0;
            r_pos       <= {POS_W{1'b0}};
        end else begin
            r_sm <= enable;
            case (r_state)
                IDLE: begin
                    if (w_decide) begin
                        r_zone <= w_zone;
                        if (w_zone == HOLD) begin
                            r_in_window <= 1'b1;
                        end else begin
                            r_in_window <= 1'b0;
                            r_busy      <= 1'b1;
                            if (w_new_dir != r_dir) begin
                                r_dir   <= w_new_dir;
                                r_state <= DIR;
                            end else begin
                                r_state <= PULSE_HI;
                                r_step  <= 1'b1;
                                r_pos   <= r_pos + w_pos_step;
                            end
                        end
                    end
                end
                DIR: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_done) begin
                        r_state <= PULSE_HI;
                        r_step  <= 1'b1;
                        r_pos   <= r_pos + w_pos_step;
                    end
                end
                PULSE_HI: begin
                    // A started pulse always runs its full width, even if enable drops
                    if (w_done) begin
                        r_step <= 1'b0;
                        if (enable) begin
                            r_state <= PULSE_LO;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                PULSE_LO: begin
                    if (!enable || w_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_step  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign drv_SM    = r_sm;
    assign drv_step  = r_step;
    assign drv_dir   = r_dir;
    assign in_window = r_in_window;
    assign busy      = r_busy;
    assign pos       = r_pos;

endmodule

// File: tb/tb_tr_track_stepper.sv
// Directed self-checking bench for tr_track_stepper (x0=100, dx1=5, dx2=20, 4/40/10/3 timing).
// With TR_AVG_EN defined only the averaging scenario runs.
module tb_tr_track_stepper;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               data_valid;
    logic [11:0]        x;
    logic [11:0]        x0;
    logic [11:0]        dx1;
    logic [11:0]        dx2;
    logic               drv_SM;
    logic               drv_step;
    logic               drv_dir;
    logic               in_window;
    logic               busy;
    logic signed [15:0] pos;

    int n_cmp  = 0;
    int n_fail = 0;
    int hi;
    int lo;
    int nd;

    tr_track_stepper #(
        .W         (12),
        .POS_W     (16),
        .PULSE_W   (4),
        .SLOW_DIV  (40),
        .FAST_DIV  (10),
        .DIR_SETUP (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data_valid (data_valid),
        .x          (x),
        .x0         (x0),
        .dx1        (dx1),
        .dx2        (dx2),
        .drv_SM     (drv_SM),
        .drv_step   (drv_step),
        .drv_dir    (drv_dir),
        .in_window  (in_window),
        .busy       (busy),
        .pos        (pos)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [11:0] v);
        x          = v;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    // Count remaining high cycles of the current pulse, then low cycles while still busy
    task automatic measure(output int h, output int l);
        int g;
        h = 0;
        l = 0;
        g = 0;
        while (drv_step === 1'b1 && g < 500) begin
            h++;
            g++;
            tick();
        end
        while (drv_step === 1'b0 && busy === 1'b1 && g < 500) begin
            l++;
            g++;
            tick();
        end
        if (g >= 500) begin
            chk("measure_timeout", g, 0);
        end
    endtask

    // Count direction-setup cycles (busy with no pulse yet)
    task automatic count_dir(output int n);
        n = 0;
        while (busy === 1'b1 && drv_step === 1'b0 && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        data_valid = 1'b0;
        x          = 12'd0;
        x0         = 12'd100;
        dx1        = 12'd5;
        dx2        = 12'd20;
        tick();
        tick();
        chk("rst_step", drv_step, 0);
        chk("rst_dir", drv_dir, 0);
        chk("rst_sm", drv_SM, 0);
        chk("rst_win", in_window, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pos", pos, 0);

        rst    = 1'b0;
        enable = 1'b1;
        tick();
        chk("sm_follows_enable", drv_SM, 1);

`ifdef TR_AVG_EN
        sample(12'd96);
        sample(12'd100);
        sample(12'd104);
        sample(12'd120);
        tick();
        chk("avg_hold_win", in_window, 1);
        chk("avg_hold_busy", busy, 0);
        chk("avg_hold_step", drv_step, 0);
        repeat (4) sample(12'd130);
        tick();
        chk("avg_fast_busy", busy, 1);
        chk("avg_fast_step", drv_step, 1);
        chk("avg_fast_dir", drv_dir, 0);
        chk("avg_fast_pos", pos, -1);
        chk("avg_fast_win", in_window, 0);
        measure(hi, lo);
        chk("avg_fast_hi", hi, 4);
        chk("avg_fast_lo", lo, 6);
`else
        // 1: inside the deadband
        sample(12'd103);
        chk("t1_win", in_window, 1);
        chk("t1_busy", busy, 0);
        chk("t1_step", drv_step, 0);
        chk("t1_pos", pos, 0);

        // 2: slow zone, direction unchanged from reset
        sample(12'd110);
        chk("t2_step", drv_step, 1);
        chk("t2_dir", drv_dir, 0);
        chk("t2_pos", pos, -1);
        chk("t2_win", in_window, 0);
        measure(hi, lo);
        chk("t2_hi", hi, 4);
        chk("t2_lo", lo, 36);
        sample(12'd110);
        chk("t2_pos2", pos, -2);
        measure(hi, lo);
        chk("t2_lo2", lo, 36);

        // Zone boundaries: |e|=dx1 holds, |e|=dx2 is slow, dx2+1 is fast
        sample(12'd105);
        chk("b_dx1_win", in_window, 1);
        chk("b_dx1_busy", busy, 0);
        chk("b_dx1_pos", pos, -2);
        sample(12'd120);
        chk("b_dx2_pos", pos, -3);
        measure(hi, lo);
        chk("b_dx2_lo", lo, 36);
        sample(12'd121);
        chk("b_fast_pos", pos, -4);
        measure(hi, lo);
        chk("b_fast_lo", lo, 6);

        // data_valid during a step is ignored
        sample(12'd121);
        chk("ign_pos", pos, -5);
        tick();
        sample(12'd60);
        measure(hi, lo);
        chk("ign_hi_rest", hi, 2);
        chk("ign_lo", lo, 6);
        chk("ign_dir", drv_dir, 0);
        chk("ign_pos2", pos, -5);

        // 3: reversal with direction setup, fast zone
        sample(12'd60);
        chk("t3_dir", drv_dir, 1);
        chk("t3_busy", busy, 1);
        chk("t3_step0", drv_step, 0);
        chk("t3_pos0", pos, -5);
        count_dir(nd);
        chk("t3_dir_cycles", nd, 3);
        chk("t3_pos1", pos, -4);
        measure(hi, lo);
        chk("t3_hi", hi, 4);
        chk("t3_lo", lo, 6);
        sample(12'd60);
        chk("t3_nowait_step", drv_step, 1);
        chk("t3_pos2", pos, -3);
        measure(hi, lo);
        chk("t3_lo2", lo, 6);

        // 4: enable dropped in cycle 2 of PULSE_HI
        sample(12'd60);
        chk("t4_pos", pos, -2);
        tick();
        enable = 1'b0;
        tick();
        chk("t4_sm", drv_SM, 0);
        chk("t4_step_c3", drv_step, 1);
        tick();
        chk("t4_step_c4", drv_step, 1);
        tick();
        chk("t4_step_end", drv_step, 0);
        chk("t4_busy_end", busy, 0);
        sample(12'd110);
        tick();
        chk("t4_no_step", drv_step, 0);
        chk("t4_no_busy", busy, 0);
        chk("t4_pos_kept", pos, -2);

        // 5: asynchronous reset mid PULSE_LO, then mid PULSE_HI
        enable = 1'b1;
        tick();
        sample(12'd60);
        chk("t5_pos", pos, -1);
        repeat (6) tick();
        chk("t5_in_lo_step", drv_step, 0);
        chk("t5_in_lo_busy", busy, 1);
        chk("t5_in_lo_dir", drv_dir, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_step", drv_step, 0);
        chk("t5_rst_pos", pos, 0);
        chk("t5_rst_dir", drv_dir, 0);
        chk("t5_rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        sample(12'd110);
        chk("t5_resume_step", drv_step, 1);
        chk("t5_resume_pos", pos, -1);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_hi_step", drv_step, 0);
        chk("t5_rst_hi_pos", pos, 0);
        rst = 1'b0;
        tick();
        sample(12'd110);
        chk("t5_resume2_pos", pos, -1);
        measure(hi, lo);
        chk("t5_resume2_hi", hi, 4);
        chk("t5_resume2_lo", lo, 36);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
